// File: rtl/ts_out_stub_window_match_pkg.sv
// Shared constants and stub x type for the outer-stub window matcher.
package ts_out_stub_window_match_pkg;
    localparam int STUB_X_PHY_BITS = 13;
    localparam int DEF_NUM_WIN     = 4;
    localparam int DEF_CNT_BITS    = 8;

    typedef logic signed [STUB_X_PHY_BITS-1:0] stub_x_t;
endpackage

// File: rtl/ts_out_stub_window_match_win_cmp_cell.sv
// One window slot: boundary registers, valid bit and signed in-window compare.
module ts_win_cmp_cell
    import ts_out_stub_window_match_pkg::*;
#(
    parameter int X_BITS    = STUB_X_PHY_BITS,
    parameter int INCLUSIVE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     load,
    input  logic signed [X_BITS-1:0] plus,
    input  logic signed [X_BITS-1:0] minus,
    input  logic signed [X_BITS-1:0] x,
    output logic                     vld,
    output logic                     hit
);
    logic signed [X_BITS-1:0] plus_q;
    logic signed [X_BITS-1:0] minus_q;
    logic                     in_win;

    // A load overrides a same-cycle clear; an inverted window empties the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            plus_q  <= '0;
            minus_q <= '0;
            vld     <= 1'b0;
        end else if (load) begin
            if (plus >= minus) begin
                plus_q  <= plus;
                minus_q <= minus;
                vld     <= 1'b1;
            end else begin
                plus_q  <= '0;
                minus_q <= '0;
                vld     <= 1'b0;
            end
        end else if (clear) begin
            vld <= 1'b0;
        end
    end

    generate
        if (INCLUSIVE != 0) begin : g_incl
            assign in_win = (x >= minus_q) && (x <= plus_q);
        end else begin : g_excl
            assign in_win = (x > minus_q) && (x < plus_q);
        end
    endgenerate

    assign hit = vld && in_win;
endmodule

// File: rtl/ts_out_stub_window_match.sv
// Compares each outer-layer stub against a bank of projected x-windows (2-stage pipeline).
module ts_out_stub_window_match
    import ts_out_stub_window_match_pkg::*;
#(
    parameter int X_BITS    = STUB_X_PHY_BITS,
    parameter int NUM_WIN   = DEF_NUM_WIN,
    parameter int IDX_BITS  = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1,
    parameter int CNT_BITS  = DEF_CNT_BITS,
    parameter int INCLUSIVE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     win_load,
    input  logic [IDX_BITS-1:0]      win_idx,
    input  logic signed [X_BITS-1:0] win_plus,
    input  logic signed [X_BITS-1:0] win_minus,
    input  logic                     win_clear,
    input  logic                     stub_valid,
    input  logic signed [X_BITS-1:0] stub_dat,
    output logic [NUM_WIN-1:0]       win_valid,
    output logic                     match_valid,
    output logic [NUM_WIN-1:0]       match_vec,
    output logic                     match_any,
    output logic [IDX_BITS-1:0]      match_idx,
    output logic [CNT_BITS-1:0]      match_count,
    output logic                     bad_win
);
    logic [NUM_WIN-1:0] hit_p0;
    logic [NUM_WIN-1:0] raw_p1;
    logic               vld_p1;
    logic               idx_ok;

    function automatic logic [IDX_BITS-1:0] lowest_idx(input logic [NUM_WIN-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = IDX_BITS'(i);
        end
    endfunction

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
        sat_inc = (&c) ? c : c + CNT_BITS'(1);
    endfunction

    assign idx_ok = 32'(win_idx) < NUM_WIN;

    generate
        for (genvar i = 0; i < NUM_WIN; i++) begin : g_win
            ts_win_cmp_cell #(
                .X_BITS   (X_BITS),
                .INCLUSIVE(INCLUSIVE)
            ) u_cell (
                .clk  (clk),
                .rst  (rst),
                .clear(win_clear),
                .load (win_load && idx_ok && (win_idx == IDX_BITS'(i))),
                .plus (win_plus),
                .minus(win_minus),
                .x    (stub_dat),
                .vld  (win_valid[i]),
                .hit  (hit_p0[i])
            );
        end
    endgenerate

    // Stage 1: raw hits against the bank as it stood before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            raw_p1 <= '0;
        end else begin
            vld_p1 <= stub_valid;
            raw_p1 <= {NUM_WIN{stub_valid}} & hit_p0;
        end
    end

    // Stage 2: registered results, priority index and saturating count.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_valid <= 1'b0;
            match_vec   <= '0;
            match_any   <= 1'b0;
            match_idx   <= '0;
            match_count <= '0;
            bad_win     <= 1'b0;
        end else begin
            match_valid <= vld_p1;
            match_vec   <= raw_p1;
            match_any   <= |raw_p1;
            match_idx   <= lowest_idx(raw_p1);
            if (win_clear) begin
                match_count <= '0;
            end else if (vld_p1 && |raw_p1) begin
                match_count <= sat_inc(match_count);
            end
            if (win_load && idx_ok && (win_plus < win_minus)) begin
                bad_win <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ts_out_stub_window_match.sv
// Bench for ts_out_stub_window_match: inclusive and exclusive instances against a behavioural model.
module tb_ts_out_stub_window_match;
    localparam int XB = 13;
    localparam int NW = 4;
    localparam int CB = 4;
    localparam int CMAX = 15;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 win_load;
    logic [1:0]           win_idx;
    logic signed [XB-1:0] win_plus;
    logic signed [XB-1:0] win_minus;
    logic                 win_clear;
    logic                 stub_valid;
    logic signed [XB-1:0] stub_dat;

    logic [NW-1:0] a_wv, b_wv, a_vec, b_vec;
    logic          a_mv, b_mv, a_any, b_any, a_bad, b_bad;
    logic [1:0]    a_idx, b_idx;
    logic [CB-1:0] a_cnt, b_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ts_out_stub_window_match #(.X_BITS(XB), .NUM_WIN(NW), .CNT_BITS(CB), .INCLUSIVE(1)) dut_a (
        .clk(clk), .rst(rst), .win_load(win_load), .win_idx(win_idx), .win_plus(win_plus),
        .win_minus(win_minus), .win_clear(win_clear), .stub_valid(stub_valid), .stub_dat(stub_dat),
        .win_valid(a_wv), .match_valid(a_mv), .match_vec(a_vec), .match_any(a_any),
        .match_idx(a_idx), .match_count(a_cnt), .bad_win(a_bad));

    ts_out_stub_window_match #(.X_BITS(XB), .NUM_WIN(NW), .CNT_BITS(CB), .INCLUSIVE(0)) dut_b (
        .clk(clk), .rst(rst), .win_load(win_load), .win_idx(win_idx), .win_plus(win_plus),
        .win_minus(win_minus), .win_clear(win_clear), .stub_valid(stub_valid), .stub_dat(stub_dat),
        .win_valid(b_wv), .match_valid(b_mv), .match_vec(b_vec), .match_any(b_any),
        .match_idx(b_idx), .match_count(b_cnt), .bad_win(b_bad));

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: window bank as arrays, results delayed by a two-entry pipeline.
    int         m_plus[NW], m_minus[NW];
    logic [3:0] m_wval;
    bit         m_bad;
    bit         s1_v;
    logic [3:0] s1_raw[2];
    bit         e_valid;
    logic [3:0] e_vec[2];
    bit         e_any[2];
    int         e_idx[2];
    int         e_cnt[2];
    bit         started = 0;
    int         tx, tp, tm, ti;

    function automatic bit in_win(input int k, input int x, input int lo, input int hi);
        if (k == 0) return (x >= lo) && (x <= hi);
        return (x > lo) && (x < hi);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_wval = '0;
            m_bad = 0;
            s1_v = 0;
            e_valid = 0;
            for (int k = 0; k < 2; k++) begin
                s1_raw[k] = '0; e_vec[k] = '0; e_any[k] = 0; e_idx[k] = 0; e_cnt[k] = 0;
            end
            for (int i = 0; i < NW; i++) begin
                m_plus[i] = 0; m_minus[i] = 0;
            end
        end else begin
            e_valid = s1_v;
            for (int k = 0; k < 2; k++) begin
                e_vec[k] = s1_raw[k];
                e_any[k] = (s1_raw[k] != 0);
                e_idx[k] = 0;
                for (int i = NW - 1; i >= 0; i--) if (s1_raw[k][i]) e_idx[k] = i;
                if (win_clear) e_cnt[k] = 0;
                else if (s1_v && e_any[k] && e_cnt[k] < CMAX) e_cnt[k]++;
            end
            tx = stub_dat;
            s1_v = stub_valid;
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < NW; i++)
                    s1_raw[k][i] = stub_valid && m_wval[i] && in_win(k, tx, m_minus[i], m_plus[i]);
            if (win_clear) m_wval = '0;
            if (win_load) begin
                tp = win_plus; tm = win_minus; ti = win_idx;
                if (tp >= tm) begin
                    m_plus[ti] = tp; m_minus[ti] = tm; m_wval[ti] = 1'b1;
                end else begin
                    m_plus[ti] = 0; m_minus[ti] = 0; m_wval[ti] = 1'b0; m_bad = 1;
                end
            end
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("a_win_valid", a_wv, m_wval);   chk("b_win_valid", b_wv, m_wval);
            chk("a_bad_win", a_bad, m_bad);     chk("b_bad_win", b_bad, m_bad);
            chk("a_match_valid", a_mv, e_valid); chk("b_match_valid", b_mv, e_valid);
            chk("a_match_vec", a_vec, e_vec[0]); chk("b_match_vec", b_vec, e_vec[1]);
            chk("a_match_any", a_any, e_any[0]); chk("b_match_any", b_any, e_any[1]);
            chk("a_match_idx", a_idx, e_idx[0]); chk("b_match_idx", b_idx, e_idx[1]);
            chk("a_match_count", a_cnt, e_cnt[0]); chk("b_match_count", b_cnt, e_cnt[1]);
        end
    end

    task automatic clr_in();
        win_load = 0; win_clear = 0; stub_valid = 0;
    endtask

    task automatic load(input int idx, input int minus, input int plus);
        win_load = 1; win_idx = 2'(idx); win_minus = 13'(minus); win_plus = 13'(plus);
    endtask

    task automatic stub(input int x);
        stub_valid = 1; stub_dat = 13'(x);
    endtask

    int xs[5] = '{-10, 10, 11, -11, 0};
    bit ea[5] = '{1, 1, 0, 0, 1};
    bit eb[5] = '{0, 0, 0, 0, 1};
    int rm;

    initial begin
        rst = 1; clr_in(); win_idx = 0; win_plus = 0; win_minus = 0; stub_dat = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_win_valid", a_wv, 0); chk("rst_match_valid", a_mv, 0);
        chk("rst_count", a_cnt, 0);    chk("rst_bad_win", a_bad, 0);

        // Inclusive vs exclusive boundaries on slot0 = (-10, +10)
        load(0, -10, 10);
        @(negedge clk); clr_in();
        chk("load0_valid", a_wv, 4'b0001);
        for (int j = 0; j < 7; j++) begin
            if (j >= 2) begin
                chk("incl_vec0", a_vec[0], ea[j-2]);
                chk("excl_vec0", b_vec[0], eb[j-2]);
                chk("bound_mv", a_mv, 1);
            end
            clr_in();
            if (j < 5) stub(xs[j]);
            @(negedge clk);
        end
        clr_in();

        // Priority, with clear and load in the same cycle
        win_clear = 1; load(1, 0, 50);
        @(negedge clk); clr_in(); load(3, 0, 50);
        @(negedge clk); clr_in(); load(2, 100, 200);
        @(negedge clk); clr_in();
        chk("prio_win_valid", a_wv, 4'b1110);
        stub(20);
        @(negedge clk); clr_in();
        @(negedge clk);
        chk("prio_vec", a_vec, 4'b1010); chk("prio_idx", a_idx, 1); chk("prio_any", a_any, 1);

        // Inverted window load
        load(2, 5, -5);
        @(negedge clk); clr_in();
        chk("bad_slot2", a_wv[2], 0); chk("bad_set", a_bad, 1);
        win_clear = 1;
        @(negedge clk); clr_in();
        chk("bad_sticky", a_bad, 1); chk("clear_wv", a_wv, 0);

        // Load and stub in the same cycle see the old (empty) bank
        load(0, 0, 5); stub(3);
        @(negedge clk); clr_in(); stub(3);
        @(negedge clk); clr_in();
        chk("same_cyc_mv", a_mv, 1); chk("same_cyc_vec", a_vec, 0);
        @(negedge clk);
        chk("next_stub_vec", a_vec, 4'b0001);

        // Counter saturation then clear
        for (int j = 0; j < 20; j++) begin
            clr_in(); stub(2);
            @(negedge clk);
        end
        clr_in();
        repeat (3) @(negedge clk);
        chk("sat_a", a_cnt, 15); chk("sat_b", b_cnt, 15);
        win_clear = 1;
        @(negedge clk); clr_in();
        chk("clr_cnt", a_cnt, 0); chk("clr_wv", a_wv, 0);

        // Reset with a stub in flight
        load(1, -100, 100);
        @(negedge clk); clr_in(); stub(7);
        @(negedge clk); clr_in(); rst = 1;
        @(negedge clk); rst = 0;
        for (int j = 0; j < 4; j++) begin
            chk("rst_mid_mv", a_mv, 0); chk("rst_mid_vec", a_vec, 0);
            chk("rst_mid_cnt", a_cnt, 0); chk("rst_mid_wv", a_wv, 0);
            @(negedge clk);
        end

        // Randomized traffic
        for (int j = 0; j < 3000; j++) begin
            clr_in();
            rst = ($urandom_range(199) == 0);
            win_clear = ($urandom_range(39) == 0);
            if ($urandom_range(5) == 0) begin
                rm = int'($urandom_range(400)) - 200;
                load(int'($urandom_range(3)), rm, rm + int'($urandom_range(170)) - 20);
            end
            if ($urandom_range(1) == 0) stub(int'($urandom_range(500)) - 250);
            @(negedge clk);
        end
        clr_in(); rst = 0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ts_out_stub_window_match.md
Name: ts_out_stub_window_match

Overview:
- Multi-window successor to the single-window outer-stub x comparator in the track-seeding path.
- Holds a bank of NUM_WIN x-windows, each projected from an inner-layer stub, and compares every incoming outer-layer stub against all valid windows in parallel.
- Produces a per-window match vector, the lowest matching window index, and a saturating match counter through a 2-stage pipeline.
- Sits between the inner-stub window projector and the tracklet builder.

Parameters:
- X_BITS, 13, signed stub x width; top-level instance ties it to `STUB_X_PHY_BITS.
- NUM_WIN, 4, number of window slots (≥1).
- IDX_BITS, $clog2(NUM_WIN) (min 1), window index width.
- CNT_BITS, 8, width of the saturating match counter.
- INCLUSIVE, 1, 1 = boundaries inclusive (minus ≤ x ≤ plus); 0 = exclusive (minus < x < plus).

Ports:
- clk  in  1  processing clock
- rst  in  1  synchronous active-high reset
- win_load  in  1  write window slot win_idx this cycle
- win_idx  in  IDX_BITS  slot to write
- win_plus  in  X_BITS signed  upper boundary
- win_minus  in  X_BITS signed  lower boundary
- win_clear  in  1  invalidate all slots, zero counter
- stub_valid  in  1  stub_dat is valid
- stub_dat  in  X_BITS signed  outer-layer stub x
- win_valid  out  NUM_WIN  per-slot valid bits
- match_valid  out  1  outputs below are valid
- match_vec  out  NUM_WIN  slot i matched
- match_any  out  1  OR of match_vec
- match_idx  out  IDX_BITS  lowest matching slot; 0 if none
- match_count  out  CNT_BITS  saturating count of stubs with match_any
- bad_win  out  1  sticky: a load was issued with plus < minus

Behaviour:
- Reset: all window registers, win_valid, match_valid, match_vec, match_any, match_idx, match_count and bad_win go to 0 on the first rising edge with rst=1.
  - A stub in flight when reset is asserted is dropped; it does not appear on match_valid.
- Window load:
  - On win_load, slot win_idx takes win_plus/win_minus on the next edge and its valid bit is set, provided win_plus ≥ win_minus (signed).
  - If win_plus < win_minus, the slot's registers and valid bit are cleared, and bad_win is set; bad_win is cleared only by rst.
  - A win_idx ≥ NUM_WIN is ignored.
- win_clear: all valid bits cleared and match_count zeroed on the next edge.
  - Same-cycle win_clear + win_load: the clear applies first, then the load, so only the loaded slot ends valid.
- Same-cycle win_load/win_clear and stub_valid: the stub is compared against the window bank as it was before the edge (old contents).
- Stage 1 (edge 1):
  - raw[i] = stub_valid & win_valid[i] & in_window(stub_dat, slot i), where in_window follows INCLUSIVE.
  - All comparisons are signed, full X_BITS; no truncation.
  - v1 <= stub_valid.
- Stage 2 (edge 2):
  - match_vec <= raw; match_any <= |raw.
  - match_idx <= lowest i with raw[i], else 0.
  - match_valid <= v1.
  - When v1 & |raw, match_count increments, saturating at 2^CNT_BITS−1; it holds at saturation.
- Latency: stub_valid at edge N gives match_valid at edge N+2. Throughput is 1 stub per cycle; there is no backpressure.
- When match_valid=0, match_vec, match_any and match_idx are 0.
- A stub accepted with no valid windows produces match_valid=1 with all-zero results.
- win_clear arriving with a stage-2 increment: the clear wins, and the count is 0.

Decomposition:
- Shared package/`include (Constants.txt): STUB_X_PHY_BITS; the default NUM_WIN and CNT_BITS; and a stub_x_t typedef if the build uses SV.
- Natural sub-module: ts_win_cmp_cell — one slot's window register plus signed in_window compare, instantiated NUM_WIN times via generate.
- Priority encoder and counter live in the top module.

Test Plan:
- Inclusive boundaries: load slot0 = (−10, +10); stubs −10, 10, 11, −11 → match_vec[0] = 1, 1, 0, 0, each 2 cycles after its stub.
- INCLUSIVE=0, same window: stubs −10, 0, 10 → match_vec[0] = 0, 1, 0.
- Priority: slots 1 and 3 loaded with (0, 50), slot 2 with (100, 200); stub 20 → match_vec = 4'b1010, match_idx = 1, match_any = 1.
- Bad load: load slot2 with plus = −5, minus = 5 → win_valid[2] = 0 and bad_win = 1, and bad_win stays 1 after a win_clear.
- Same-cycle load and stub: load slot0 = (0, 5) with stub 3 in the same cycle → no match (old bank invalid); the next stub 3 → match.
- Saturation and clear: CNT_BITS=4, 20 matching stubs back-to-back → match_count stops at 15; win_clear → count 0 and win_valid = 0.
- Reset mid-stream: stub accepted, rst asserted the next cycle → match_valid is never 1 for that stub and all outputs are 0.
